param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register and data width.
REQ-002 Parameter ADDR_W, default 3, SHALL set the register count NREG = 2**ADDR_W.
REQ-003 Parameter RA_ADDR_W, default 2, SHALL set the port-1 address width, limiting port 1 to registers 0..2**RA_ADDR_W-1, with RA_ADDR_W <= ADDR_W.
REQ-004 Parameter BRANCH_IDX, default NREG-1, SHALL select the register mirrored on branch_val.
REQ-005 Port clock, input, 1: single clock; all state changes occur on its falling edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port write_ctrl, input, 1: write enable.
REQ-008 Port write_reg, input, ADDR_W: write address.
REQ-009 Port write_val, input, DATA_W: write data.
REQ-010 Port swap_ctrl, input, 1: exchange the registers addressed by read_reg1 and read_reg2.
REQ-011 Port read_reg1, input, RA_ADDR_W: read address, port 1.
REQ-012 Port read_reg2, input, ADDR_W: read address, port 2.
REQ-013 Port reserve_ctrl, input, 1: mark reserve_reg as awaiting a pending write.
REQ-014 Port reserve_reg, input, ADDR_W: reservation address.
REQ-015 Ports read_val1 and read_val2, output, DATA_W each: read data.
REQ-016 Port branch_val, output, DATA_W: value of register BRANCH_IDX.
REQ-017 Ports busy1 and busy2, output, 1 each: busy bit of read_reg1 and read_reg2 respectively.
REQ-018 Port swap_fault, output, 1: registered pulse flagging a rejected swap.

Function
REQ-019 Register 0 SHALL always read 0, ignore writes and swaps, and never be busy.
REQ-020 Reads SHALL be combinational; when write_ctrl=1, write_reg equals a nonzero read address, and that register is not a swap target this cycle, the read port SHALL return write_val (forwarding).
REQ-021 branch_val SHALL follow the stored value of BRANCH_IDX, without forwarding.
REQ-022 A write with write_ctrl=1 SHALL update write_reg on the falling edge and clear its busy bit.
REQ-023 A reservation with reserve_ctrl=1 SHALL set busy[reserve_reg] on the falling edge.
REQ-024 If a reservation and a write target the same register in the same cycle, the data SHALL be written and the busy bit SHALL end set.
REQ-025 A swap SHALL exchange the pre-edge stored values (not forwarded values) of read_reg1 and read_reg2 (port-1 address zero-extended).
REQ-026 A swap involving register 0 SHALL write 0 to the other register.
REQ-027 A swap with equal addresses SHALL change nothing.
REQ-028 A swap where either register is busy SHALL be suppressed, and swap_fault SHALL be 1 for the following cycle.
REQ-029 If a write and a valid swap occur together, the swap SHALL win on the swapped registers, and the write SHALL still apply to any other register.
REQ-030 Busy bits SHALL be unaffected by swaps.
REQ-031 swap_fault SHALL otherwise be 0.

Reset
REQ-032 On reset_n=0, immediately and independently of the clock: all registers SHALL be 0, all busy bits SHALL be 0, and swap_fault SHALL be 0.
REQ-033 Consequently, after reset read_val1, read_val2 and branch_val SHALL read 0, except where forwarding from write_val applies.
REQ-034 A reset asserted mid-cycle SHALL discard any write, swap or reservation pending for that edge.
REQ-035 On the first falling edge after reset_n rises, the block SHALL operate normally.

Structure
REQ-036 Default widths, the register-0 index and the default branch index SHALL live in a shared package, param_regfile_pkg.
REQ-037 The busy-bit scoreboard SHALL be the single sub-module regfile_scoreboard (set/clear/query, with asynchronous reset).

Verification
REQ-038 Reset, then write 0x5A to r3 -> read_reg2=3 returns 0x5A; while the write is pending, the port returns 0x5A before the edge.
REQ-039 r2=0x11, r6=0x22, swap with read_reg1=2 and read_reg2=6 -> r2=0x22, r6=0x11; a simultaneous write of 0x33 to r4 -> r4=0x33.
REQ-040 Reserve r5, then swap r1 with r5 -> no change, and swap_fault is 1 for one cycle; write r5=0x44 -> busy2 goes to 0 and the swap then succeeds.
REQ-041 Write 0xFF to r0 -> reads 0; swap r0 with r7 -> r7=0 and branch_val=0.
REQ-042 Reserve and write r3 in the same cycle -> r3 holds the new data and busy remains 1.
REQ-043 Assert reset_n low between edges with writes pending -> all outputs are 0 at once, and no write lands.

Source files
------------

// File: rtl/param_regfile_pkg.sv
// Shared defaults for the parameterised register file and its busy scoreboard.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package param_regfile_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 3;
  localparam int RA_ADDR_W_DEF = 2;

  // Hard-wired zero register.
  localparam int REG_ZERO = 0;

  // The branch mirror defaults to the highest-numbered register.
  function automatic int branch_idx_def(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by reservations, cleared by writes.
// Latency: set/clear land on the falling clock edge; queries are combinational.
// Backpressure: none; set wins over clear on the same register, register 0 never busy.
// Ports: clock/reset_n; set_vld/set_addr, clr_vld/clr_addr; qry_a/b_addr -> busy_a/b.
module regfile_scoreboard
  import param_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_vld,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_vld,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] qry_a_addr,
  input  logic [ADDR_W-1:0] qry_b_addr,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_vld) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a same-cycle reserve+write leaves the bit set.
    if (set_vld) busy_d[set_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a = busy_q[qry_a_addr];
  assign busy_b = busy_q[qry_b_addr];

endmodule

// File: rtl/param_register_file.sv
// Register file with write forwarding, guarded register swap, busy scoreboard, branch mirror.
// Latency: reads combinational (write data forwarded); state updates on the falling edge.
// Backpressure: swaps touching a busy register are dropped and flagged on swap_fault next cycle.
// Ports: write_ctrl/reg/val; swap_ctrl; read_reg1 (narrow), read_reg2; reserve_ctrl/reg;
//        read_val1/2, busy1/2, branch_val (stored value of BRANCH_IDX), swap_fault.
module param_register_file
  import param_regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RA_ADDR_W  = RA_ADDR_W_DEF,
  parameter int BRANCH_IDX = branch_idx_def(ADDR_W)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 write_ctrl,
  input  logic [ADDR_W-1:0]    write_reg,
  input  logic [DATA_W-1:0]    write_val,
  input  logic                 swap_ctrl,
  input  logic [RA_ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0]    read_reg2,
  input  logic                 reserve_ctrl,
  input  logic [ADDR_W-1:0]    reserve_reg,
  output logic [DATA_W-1:0]    read_val1,
  output logic [DATA_W-1:0]    read_val2,
  output logic [DATA_W-1:0]    branch_val,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 swap_fault
);

  localparam int                NREG      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] BR_ADDR   = ADDR_W'(BRANCH_IDX);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              swap_fault_q;
  logic              swap_fault_d;

  logic [ADDR_W-1:0] rd1_addr;
  logic              swap_ok;
  logic              wr_ok;

  assign rd1_addr = ADDR_W'(read_reg1);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_vld    (reserve_ctrl),
    .set_addr   (reserve_reg),
    .clr_vld    (write_ctrl),
    .clr_addr   (write_reg),
    .qry_a_addr (rd1_addr),
    .qry_b_addr (read_reg2),
    .busy_a     (busy1),
    .busy_b     (busy2)
  );

  // Only a swap that actually moves data counts; equal addresses are a no-op.
  assign swap_ok = swap_ctrl && !busy1 && !busy2 && (rd1_addr != read_reg2);

  // A write lands unless it is register 0 or a register being overwritten by the swap.
  // The same condition gates forwarding, so the read port shows what will be stored.
  assign wr_ok = write_ctrl && (write_reg != ZERO_ADDR) &&
                 !(swap_ok && ((write_reg == rd1_addr) || (write_reg == read_reg2)));

  assign read_val1  = (wr_ok && (write_reg == rd1_addr))  ? write_val : regs_q[rd1_addr];
  assign read_val2  = (wr_ok && (write_reg == read_reg2)) ? write_val : regs_q[read_reg2];
  assign branch_val = regs_q[BR_ADDR];
  assign swap_fault = swap_fault_q;

  always_comb begin
    regs_d = regs_q;
    if (swap_ok) begin
      // Exchange stored (pre-edge) values; regs_q[0] is always 0, so a swap
      // with register 0 clears the partner.
      regs_d[rd1_addr]  = regs_q[read_reg2];
      regs_d[read_reg2] = regs_q[rd1_addr];
    end
    if (wr_ok) regs_d[write_reg] = write_val;
    regs_d[REG_ZERO] = '0;
  end

  assign swap_fault_d = swap_ctrl && (busy1 || busy2);

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      swap_fault_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      swap_fault_q <= swap_fault_d;
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

  logic       clock = 1'b1;
  logic       reset_n = 1'b0;
  logic       write_ctrl = 1'b0;
  logic [2:0] write_reg = '0;
  logic [7:0] write_val = '0;
  logic       swap_ctrl = 1'b0;
  logic [1:0] read_reg1 = '0;
  logic [2:0] read_reg2 = '0;
  logic       reserve_ctrl = 1'b0;
  logic [2:0] reserve_reg = '0;
  logic [7:0] read_val1, read_val2, branch_val;
  logic       busy1, busy2, swap_fault;

  always #5 clock = ~clock;

  param_register_file dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_ctrl   (write_ctrl),
    .write_reg    (write_reg),
    .write_val    (write_val),
    .swap_ctrl    (swap_ctrl),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .reserve_ctrl (reserve_ctrl),
    .reserve_reg  (reserve_reg),
    .read_val1    (read_val1),
    .read_val2    (read_val2),
    .branch_val   (branch_val),
    .busy1        (busy1),
    .busy2        (busy2),
    .swap_fault   (swap_fault)
  );

  // Reference state: register contents, busy flags, last-cycle fault flag.
  int m_reg  [8] = '{default: 0};
  bit m_busy [8] = '{default: 1'b0};
  bit m_fault = 1'b0;
  int nxt    [8];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // A swap moves data only with two distinct, idle registers.
  function automatic bit swap_moves();
    int a, b;
    a = int'(read_reg1);
    b = int'(read_reg2);
    return swap_ctrl && (a != b) && !m_busy[a] && !m_busy[b];
  endfunction

  function automatic int exp_read(input int a);
    bit swapped;
    swapped = swap_moves() && (a == int'(read_reg1) || a == int'(read_reg2));
    if (write_ctrl && int'(write_reg) == a && a != 0 && !swapped) return int'(write_val);
    return m_reg[a];
  endfunction

  // Reference update on each falling edge, or immediately on reset.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 0;
        m_busy[i] = 1'b0;
      end
      m_fault = 1'b0;
    end else begin
      int a, b, w;
      a = int'(read_reg1);
      b = int'(read_reg2);
      w = int'(write_reg);
      for (int i = 0; i < 8; i++) nxt[i] = m_reg[i];
      if (swap_moves()) begin
        nxt[a] = m_reg[b];
        nxt[b] = m_reg[a];
      end
      if (write_ctrl && w != 0 && !(swap_moves() && (w == a || w == b)))
        nxt[w] = int'(write_val);
      nxt[0] = 0;
      m_fault = swap_ctrl && (m_busy[a] || m_busy[b]);
      if (write_ctrl) m_busy[w] = 1'b0;
      if (reserve_ctrl && reserve_reg != 3'd0) m_busy[int'(reserve_reg)] = 1'b1;
      for (int i = 0; i < 8; i++) m_reg[i] = nxt[i];
    end
  end

  // Continuous comparison, sampled on the rising edge (away from the active falling edge).
  always @(posedge clock) begin
    if (chk_en) begin
      chk("m_read_val1",  int'(read_val1),  exp_read(int'(read_reg1)));
      chk("m_read_val2",  int'(read_val2),  exp_read(int'(read_reg2)));
      chk("m_branch_val", int'(branch_val), m_reg[7]);
      chk("m_busy1",      int'(busy1),      int'(m_busy[int'(read_reg1)]));
      chk("m_busy2",      int'(busy2),      int'(m_busy[int'(read_reg2)]));
      chk("m_swap_fault", int'(swap_fault), int'(m_fault));
    end
  end

  task automatic apply(input bit we, input int wr, input int wv, input bit sw,
                       input int r1, input int r2, input bit rs, input int rr);
    @(negedge clock);
    #1;
    write_ctrl   = we;
    write_reg    = 3'(wr);
    write_val    = 8'(wv);
    swap_ctrl    = sw;
    read_reg1    = 2'(r1);
    read_reg2    = 3'(r2);
    reserve_ctrl = rs;
    reserve_reg  = 3'(rr);
    #1;
  endtask

  task automatic rst_pulse();
    #2;
    reset_n = 1'b0;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd1"},   int'(read_val1),  0);
    chk({tag, "_rd2"},   int'(read_val2),  0);
    chk({tag, "_br"},    int'(branch_val), 0);
    chk({tag, "_busy1"}, int'(busy1),      0);
    chk({tag, "_busy2"}, int'(busy2),      0);
    chk({tag, "_fault"}, int'(swap_fault), 0);
  endtask

  initial begin
    #2;
    chk_all_zero("reset");
    #10;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Write forwarding then stored read of r3.
    apply(1, 3, 'h5A, 0, 0, 3, 0, 0);
    chk("fwd_r3", int'(read_val2), 'h5A);
    apply(0, 0, 0, 0, 0, 3, 0, 0);
    chk("stored_r3", int'(read_val2), 'h5A);

    // Swap r2/r6 with a simultaneous unrelated write to r4.
    apply(1, 2, 'h11, 0, 0, 0, 0, 0);
    apply(1, 6, 'h22, 0, 0, 0, 0, 0);
    apply(1, 1, 'h77, 0, 0, 0, 0, 0);
    apply(1, 4, 'h33, 1, 2, 6, 0, 0);
    apply(0, 0, 0, 0, 2, 6, 0, 0);
    chk("swap_r2", int'(read_val1), 'h22);
    chk("swap_r6", int'(read_val2), 'h11);
    apply(0, 0, 0, 0, 0, 4, 0, 0);
    chk("write_r4", int'(read_val2), 'h33);

    // Reserved r5 blocks the swap and raises a one-cycle fault.
    apply(0, 0, 0, 0, 0, 0, 1, 5);
    apply(0, 0, 0, 0, 1, 5, 0, 0);
    chk("busy_r5", int'(busy2), 1);
    apply(0, 0, 0, 1, 1, 5, 0, 0);
    apply(0, 0, 0, 0, 1, 5, 0, 0);
    chk("fault_set", int'(swap_fault), 1);
    chk("blocked_r1", int'(read_val1), 'h77);
    chk("blocked_r5", int'(read_val2), 'h00);
    apply(0, 0, 0, 0, 1, 5, 0, 0);
    chk("fault_clear", int'(swap_fault), 0);
    apply(1, 5, 'h44, 0, 1, 5, 0, 0);
    chk("fwd_r5", int'(read_val2), 'h44);
    apply(0, 0, 0, 1, 1, 5, 0, 0);
    chk("busy_r5_clr", int'(busy2), 0);
    apply(0, 0, 0, 0, 1, 5, 0, 0);
    chk("swap2_r1", int'(read_val1), 'h44);
    chk("swap2_r5", int'(read_val2), 'h77);
    chk("no_fault", int'(swap_fault), 0);

    // Register 0 ignores writes; swapping with it clears the partner.
    apply(1, 0, 'hFF, 0, 0, 0, 0, 0);
    chk("r0_fwd_rd1", int'(read_val1), 0);
    chk("r0_fwd_rd2", int'(read_val2), 0);
    apply(1, 7, 'h99, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 7, 0, 0);
    chk("branch_r7", int'(branch_val), 'h99);
    apply(0, 0, 0, 1, 0, 7, 0, 0);
    apply(0, 0, 0, 0, 0, 7, 0, 0);
    chk("swap0_r7", int'(read_val2), 0);
    chk("swap0_br", int'(branch_val), 0);

    // Same-cycle reserve and write of r3.
    apply(1, 3, 'h66, 0, 0, 3, 1, 3);
    apply(0, 0, 0, 0, 0, 3, 0, 0);
    chk("resw_r3", int'(read_val2), 'h66);
    chk("resw_busy", int'(busy2), 1);

    // Mid-cycle reset with a write and a reservation pending.
    apply(1, 2, 'hAB, 0, 1, 6, 1, 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clock);
    #1;
    write_ctrl   = 1'b0;
    reserve_ctrl = 1'b0;
    reset_n      = 1'b1;
    apply(0, 0, 0, 0, 2, 4, 0, 0);
    chk("midrst_r2", int'(read_val1), 0);
    chk("midrst_busy4", int'(busy2), 0);

    // Randomised traffic against the reference, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0), $urandom_range(0, 7));
      if ($urandom_range(0, 249) == 0) rst_pulse();
    end

    apply(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
